bitlet_mac_scheduler: RTL and testbench



---
 rtl/bitlet_mac_scheduler.sv | 179 +++++++++++++++++
 tb/tb_bitlet_mac_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_mac_scheduler.sv
// Bitlet MAC scheduler: takes one weight tile, splits it into bit-plane
// columns and walks each column's set bits, one per cycle, producing the
// activation selects and the MAC control strobes for that tile.

// One bit-plane column: holds the remaining set bits for a single
// significance and yields the index of the lowest one each cycle.
module bitlet_lane #(
    parameter int VEC_LENGTH    = 32,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [VEC_LENGTH-1:0]    col_i,
    input  logic                     step_i,
    output logic [MUX_SEL_WIDTH-1:0] sel_o,
    output logic                     val_o,
    output logic                     done_o
);

    logic [VEC_LENGTH-1:0] mask_q, mask_d, mask_clr;

    // Clearing the lowest set bit retires the weight just selected.
    assign mask_clr = mask_q & (mask_q - VEC_LENGTH'(1));
    assign done_o   = (mask_clr == '0);

    // Next column contents: load a fresh tile, or retire one bit while computing.
    always_comb begin
        mask_d = mask_q;
        if (load_i)
            mask_d = col_i;
        else if (step_i)
            mask_d = mask_clr;
    end

    // Column register.
    always_ff @(posedge clk) begin
        if (reset)
            mask_q <= '0;
        else
            mask_q <= mask_d;
    end

    // Lowest set bit wins; scanning downward leaves the smallest index last.
    always_comb begin
        sel_o = '0;
        val_o = 1'b0;
        if (step_i) begin
            for (int k = VEC_LENGTH - 1; k >= 0; k--) begin
                if (mask_q[k])
                    sel_o = MUX_SEL_WIDTH'(k);
            end
            val_o = |mask_q;
        end
    end

endmodule

module bitlet_mac_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 32,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     w_valid,
    output logic                                     w_ready,
    // Bit DATA_WIDTH-1 of each weight is the negative plane; the MAC applies
    // the sign, so here it is just another column.
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    w_in,
    input  logic                                     w_first,
    output logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] act_sel,
    output logic [DATA_WIDTH-1:0]                    act_val,
    output logic                                     mac_en,
    output logic                                     load_accum,
    output logic                                     act_hold,
    output logic                                     busy,
    output logic                                     result_valid
);

    localparam int CYC_W = $clog2(VEC_LENGTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               rv_q, rv_d;

    logic                                  accept;
    logic                                  computing;
    logic [DATA_WIDTH-1:0]                 lane_done;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0] cols;

    assign w_ready   = (state_q == S_IDLE) || (state_q == S_DRAIN);
    assign accept    = w_valid && w_ready;
    assign computing = (state_q == S_COMPUTE);

    // Transpose the tile: column j gathers bit j of every weight.
    always_comb begin
        cols = '0;
        for (int j = 0; j < DATA_WIDTH; j++)
            for (int k = 0; k < VEC_LENGTH; k++)
                cols[j][k] = w_in[k][j];
    end

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_lane
        bitlet_lane #(
            .VEC_LENGTH   (VEC_LENGTH),
            .MUX_SEL_WIDTH(MUX_SEL_WIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load_i (accept),
            .col_i  (cols[j]),
            .step_i (computing),
            .sel_o  (act_sel[j]),
            .val_o  (act_val[j]),
            .done_o (lane_done[j])
        );
    end

    // Next-state and tile bookkeeping; DRAIN may accept the next tile directly.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        cyc_d   = cyc_q;
        rv_d    = (state_q == S_DRAIN);
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (&lane_done)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = accept ? S_COMPUTE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            first_d = w_first;
            cyc_d   = '0;
        end
    end

    // State registers; reset drops any tile in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            cyc_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cyc_q   <= cyc_d;
            rv_q    <= rv_d;
        end
    end

    // cyc_q counts completed COMPUTE cycles, so cyc_q==1 marks the second
    // enabled cycle both mid-COMPUTE and in DRAIN of a one-cycle tile.
    always_comb begin
        mac_en       = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
        act_hold     = computing;
        busy         = (state_q != S_IDLE);
        load_accum   = first_q && mac_en && (cyc_q == CYC_W'(1));
        result_valid = rv_q;
    end

endmodule

// File: tb/tb_bitlet_mac_scheduler.sv
// Bench for bitlet_mac_scheduler: table of tiles plus hand sequences for
// back-to-back accept and mid-tile reset, checked against a per-cycle
// expected-output queue.
module tb_bitlet_mac_scheduler;

    localparam int DW = 8;
    localparam int VL = 32;
    localparam int SW = $clog2(VL);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   w_valid;
    logic                   w_ready;
    logic [VL-1:0][DW-1:0]  w_in;
    logic                   w_first;
    logic [DW-1:0][SW-1:0]  act_sel;
    logic [DW-1:0]          act_val;
    logic                   mac_en, load_accum, act_hold, busy, result_valid;

    bitlet_mac_scheduler #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
        .clk         (clk),
        .reset       (reset),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_in        (w_in),
        .w_first     (w_first),
        .act_sel     (act_sel),
        .act_val     (act_val),
        .mac_en      (mac_en),
        .load_accum  (load_accum),
        .act_hold    (act_hold),
        .busy        (busy),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0][SW-1:0] sel;
        logic [DW-1:0]         val;
        logic                  en, la, hold, bsy, rv, rdy;
        string                 tag;
    } exp_t;

    typedef struct {
        logic [VL-1:0][DW-1:0] w;
        logic                  first;
        int                    exp_n;
        string                 tag;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mac_cnt = 0;
    vec_t tbl[5];

    function automatic void push_idle(input logic rv, input string tag);
        exp_t e;
        e.sel = '0; e.val = '0; e.en = 0; e.la = 0; e.hold = 0;
        e.bsy = 0; e.rv = rv; e.rdy = 1; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Expected compute cycles + drain for one tile; returns compute cycle count.
    function automatic int push_tile(input logic [VL-1:0][DW-1:0] w, input logic first,
                                     input logic rv_first, input string tag);
        int   n = 1;
        exp_t e;
        for (int j = 0; j < DW; j++) begin
            int pc = 0;
            for (int k = 0; k < VL; k++) if (w[k][j]) pc++;
            if (pc > n) n = pc;
        end
        for (int c = 0; c < n; c++) begin
            e.sel = '0; e.val = '0;
            for (int j = 0; j < DW; j++) begin
                int cnt = 0;
                for (int k = 0; k < VL; k++) begin
                    if (w[k][j]) begin
                        if (cnt == c) begin e.sel[j] = SW'(k); e.val[j] = 1'b1; end
                        cnt++;
                    end
                end
            end
            e.en = 1; e.la = first && (c == 1); e.hold = 1; e.bsy = 1;
            e.rv = rv_first && (c == 0); e.rdy = 0; e.tag = tag;
            exp_q.push_back(e);
        end
        e.sel = '0; e.val = '0; e.en = 1; e.la = first && (n == 1); e.hold = 0;
        e.bsy = 1; e.rv = 0; e.rdy = 1; e.tag = tag;
        exp_q.push_back(e);
        return n;
    endfunction

    // One clock, then check the DUT against the head of the queue.
    task automatic step();
        @(posedge clk);
        #2;
        if (mac_en) mac_cnt++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (act_sel !== e.sel || act_val !== e.val || mac_en !== e.en ||
                load_accum !== e.la || act_hold !== e.hold || busy !== e.bsy ||
                result_valid !== e.rv || w_ready !== e.rdy) begin
                n_fail++;
                $display("FAIL %s t=%0t got sel=%h val=%h en=%b la=%b hold=%b busy=%b rv=%b rdy=%b want sel=%h val=%h en=%b la=%b hold=%b busy=%b rv=%b rdy=%b",
                         e.tag, $time, act_sel, act_val, mac_en, load_accum, act_hold, busy,
                         result_valid, w_ready, e.sel, e.val, e.en, e.la, e.hold, e.bsy, e.rv, e.rdy);
            end
        end
    endtask

    task automatic drain_q(input string tag);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d expected cycles left, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic scramble_w();
        for (int k = 0; k < VL; k++) w_in[k] = DW'($urandom);
        w_first = 1'($urandom);
    endtask

    initial begin
        int n1;
        logic [VL-1:0][DW-1:0] t1, t2;

        // Tile table: inputs and expected compute-cycle count.
        for (int i = 0; i < 5; i++) begin tbl[i].w = '0; tbl[i].first = 1'b1; end
        tbl[0].w[5] = 8'h01; tbl[0].exp_n = 1;  tbl[0].tag = "single";
        tbl[1].w[0] = 8'h81; tbl[1].w[3] = 8'h81; tbl[1].w[31] = 8'h81;
        tbl[1].exp_n = 3;  tbl[1].tag = "sign_lsb";
        for (int k = 0; k < VL; k++) tbl[2].w[k] = 8'hFF;
        tbl[2].first = 1'b0; tbl[2].exp_n = 32; tbl[2].tag = "all_ones";
        tbl[3].exp_n = 1;  tbl[3].tag = "all_zero";
        for (int k = 0; k < VL; k++) tbl[4].w[k] = DW'(k);
        for (int k = 0; k < 10; k++) tbl[4].w[k][7] = 1'b1;
        tbl[4].exp_n = 16; tbl[4].tag = "ramp_neg";

        reset = 1'b1; w_valid = 1'b0; w_in = '0; w_first = 1'b0;
        step();
        push_idle(1'b0, "reset");
        step();
        reset = 1'b0;
        push_idle(1'b0, "post_reset");
        step();

        foreach (tbl[i]) begin
            w_valid = 1'b1; w_in = tbl[i].w; w_first = tbl[i].first;
            void'(push_tile(tbl[i].w, tbl[i].first, 1'b0, tbl[i].tag));
            push_idle(1'b1, tbl[i].tag);
            mac_cnt = 0;
            step();
            w_valid = 1'b0;
            scramble_w();
            drain_q(tbl[i].tag);
            n_tests++;
            if (mac_cnt != tbl[i].exp_n + 1) begin
                n_fail++;
                $display("FAIL %s mac_en cycles got %0d want %0d", tbl[i].tag, mac_cnt, tbl[i].exp_n + 1);
            end
        end

        // Back-to-back: second tile offered continuously, accepted in DRAIN.
        t1 = tbl[1].w; t2 = tbl[0].w;
        w_valid = 1'b1; w_in = t1; w_first = 1'b1;
        n1 = push_tile(t1, 1'b1, 1'b0, "b2b_t1");
        void'(push_tile(t2, 1'b1, 1'b1, "b2b_t2"));
        push_idle(1'b1, "b2b_end");
        mac_cnt = 0;
        step();
        w_in = t2;
        repeat (n1 + 1) step();
        w_valid = 1'b0;
        scramble_w();
        drain_q("b2b");
        n_tests++;
        if (mac_cnt != 6) begin
            n_fail++;
            $display("FAIL b2b mac_en cycles got %0d want 6", mac_cnt);
        end

        // Reset during the 3rd COMPUTE cycle of a 32-cycle tile.
        w_valid = 1'b1; w_in = tbl[2].w; w_first = 1'b0;
        void'(push_tile(tbl[2].w, 1'b0, 1'b0, "midrst"));
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        push_idle(1'b0, "midrst_idle");
        push_idle(1'b0, "midrst_idle");
        push_idle(1'b0, "midrst_idle");
        step();
        w_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drain_q("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
